// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control sequencer
package mc_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4,  CC_LS = 4'd5,  CC_GT = 4'd6,  CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8,  CC_FC = 4'd9,  CC_LO = 4'd10, CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12, CC_GE = 4'd13, CC_UC = 4'd14;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // arithmetic ops sign-extend their immediate and update the PSR
  function automatic logic is_arith_code(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_CMP);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch/jump condition evaluation against the PSR
module cond_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       take
);

  logic c, l, f, z, n;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_EQ: take = z;
      CC_NE: take = !z;
      CC_CS: take = c;
      CC_CC: take = !c;
      CC_HI: take = l;
      CC_LS: take = !l;
      CC_GT: take = n;
      CC_LE: take = !n;
      CC_FS: take = f;
      CC_FC: take = !f;
      CC_LO: take = !l && !z;
      CC_HS: take = l || z;
      CC_LT: take = !n && !z;
      CC_GE: take = n || z;
      CC_UC: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// rtl/mc_ctrl_seq.sv - multicycle fetch/decode/exec sequencer; STEP_DEBUG_EN adds halt/step
module mc_ctrl_seq
  import mc_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int RESET_PC = 0,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        rf_ra_addr,
  output logic [3:0]        rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir_out,
  output logic [4:0]        psr,
  output logic              fault,
  output logic [2:0]        state_out
`ifdef STEP_DEBUG_EN
  ,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  output logic              halted
`endif
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [2:0]        state, state_nxt, done_state;
  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_inc, bdisp;
  logic [15:0]       ir, ir_nxt;
  logic [4:0]        psr_q, psr_nxt;
  logic [WCW-1:0]    wait_cnt;
  logic              wd_hit, take;

  logic [3:0]        op, ext, code;
  logic [7:0]        imm8;
  logic              is_rr, is_lui, is_alu, is_bcond, is_jcond, is_jal, is_load, is_stor;
  logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui;

  assign op       = ir[15:12];
  assign ext      = ir[7:4];
  assign imm8     = ir[7:0];
  assign is_rr    = (op == OP_RR);
  assign code     = is_rr ? ext : op;
  assign is_lui   = (op == OP_LUI);
  assign is_alu   = is_lui || is_alu_code(code);
  assign is_bcond = (op == OP_BCOND);
  assign is_jcond = (op == OP_JMP) && (ext == EXT_JCOND);
  assign is_jal   = (op == OP_JMP) && (ext == EXT_JAL);
  assign is_load  = (op == OP_JMP) && (ext == EXT_LOAD);
  assign is_stor  = (op == OP_JMP) && (ext == EXT_STOR);

  assign imm_sext = DATA_W'($signed(imm8));
  assign imm_zext = DATA_W'(imm8);
  assign imm_lui  = DATA_W'({imm8, 8'h00});
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign bdisp    = imm_sext[ADDR_W-1:0];
  assign wd_hit   = (MAX_WAIT != 0) && (wait_cnt == WCW'(MAX_WAIT - 1));

  cond_eval u_cond (
    .cond (ir[11:8]),
    .psr  (psr_q),
    .take (take)
  );

`ifdef STEP_DEBUG_EN
  // a step in progress returns to HALT even if dbg_halt was dropped meanwhile
  logic step_pend;
  assign done_state = (dbg_halt || step_pend) ? S_HALT : S_FETCH;
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              step_pend <= 1'b0;
    else if (state == S_HALT && dbg_step) step_pend <= 1'b1;
    else if (state_nxt == S_HALT)         step_pend <= 1'b0;
  end
`else
  assign done_state = S_FETCH;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir;
    psr_nxt   = psr_q;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_nxt    = mem_rdata[15:0];
          state_nxt = S_DECODE;
        end else if (wd_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = done_state;
        if (is_alu) begin
          pc_nxt = pc_inc;
          if (is_arith_code(code)) psr_nxt = alu_flags;
        end else if (is_bcond) begin
          pc_nxt = take ? pc_q + bdisp : pc_inc;
        end else if (is_jcond) begin
          pc_nxt = take ? rf_rb_data[ADDR_W-1:0] : pc_inc;
        end else if (is_jal) begin
          pc_nxt = rf_rb_data[ADDR_W-1:0];
        end else if (is_load || is_stor) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          pc_nxt    = pc_inc;
          state_nxt = done_state;
        end else if (wd_hit) begin
          state_nxt = S_FAULT;
        end
      end
`ifdef STEP_DEBUG_EN
      S_HALT: if (dbg_step || !dbg_halt) state_nxt = S_FETCH;
`endif
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc_q     <= ADDR_W'(RESET_PC);
      ir       <= '0;
      psr_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      ir       <= ir_nxt;
      psr_q    <= psr_nxt;
      wait_cnt <= (mem_req && !mem_ready && MAX_WAIT != 0) ? wait_cnt + WCW'(1) : '0;
    end
  end

  // strobes are gated by rst so they drop the instant reset asserts
  assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = !rst && (state == S_MEM) && is_stor;
  assign mem_addr  = (state == S_MEM) ? rf_rb_data[ADDR_W-1:0] : pc_q;
  assign mem_wdata = rf_ra_data;

  assign rf_ra_addr = ir[11:8];
  assign rf_rb_addr = ir[3:0];
  assign rf_waddr   = ir[11:8];
  assign rf_we      = !rst && (((state == S_EXEC) && ((is_alu && code != OP_CMP) || is_jal))
                               || ((state == S_MEM) && is_load && mem_ready));
  assign rf_wdata   = (state == S_MEM) ? mem_rdata : (is_jal ? DATA_W'(pc_inc) : alu_out);

  assign alu_a  = rf_ra_data;
  assign alu_b  = is_rr ? rf_rb_data : is_lui ? imm_lui : is_arith_code(code) ? imm_sext : imm_zext;
  assign alu_op = {1'b0, (is_lui ? OP_MOV : code)};

  assign pc        = pc_q;
  assign ir_out    = ir;
  assign psr       = psr_q;
  assign fault     = (state == S_FAULT);
  assign state_out = state;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// tb/tb_mc_ctrl_seq.sv - directed bench for mc_ctrl_seq with memory, regfile and ALU models
module tb_mc_ctrl_seq;

  localparam int DW = 16;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          mem_req, mem_we, mem_ready, rf_we, fault;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, rf_ra_data, rf_rb_data, rf_wdata, alu_a, alu_b, alu_out;
  logic [3:0]    rf_ra_addr, rf_rb_addr, rf_waddr;
  logic [4:0]    alu_op, alu_flags, psr;
  logic [15:0]   ir_out;
  logic [2:0]    state_out;

  logic          wd_mem_req, wd_mem_we, wd_rf_we, wd_fault;
  logic [AW-1:0] wd_mem_addr, wd_pc;
  logic [DW-1:0] wd_mem_wdata, wd_rf_wdata, wd_alu_a, wd_alu_b;
  logic [3:0]    wd_rf_ra_addr, wd_rf_rb_addr, wd_rf_waddr;
  logic [4:0]    wd_alu_op, wd_psr;
  logic [15:0]   wd_ir;
  logic [2:0]    wd_state;

`ifdef STEP_DEBUG_EN
  logic dbg_halt = 1'b0, dbg_step = 1'b0, halted, wd_halted;
`endif

  mc_ctrl_seq #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0), .MAX_WAIT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
    .pc(pc), .ir_out(ir_out), .psr(psr), .fault(fault), .state_out(state_out)
`ifdef STEP_DEBUG_EN
    , .dbg_halt(dbg_halt), .dbg_step(dbg_step), .halted(halted)
`endif
  );

  // second instance with a short watchdog and a memory that never answers
  mc_ctrl_seq #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0), .MAX_WAIT(4)) dut_wd (
    .clk(clk), .rst(rst),
    .mem_req(wd_mem_req), .mem_we(wd_mem_we), .mem_addr(wd_mem_addr), .mem_wdata(wd_mem_wdata),
    .mem_rdata(16'h0000), .mem_ready(1'b0),
    .rf_ra_addr(wd_rf_ra_addr), .rf_rb_addr(wd_rf_rb_addr), .rf_ra_data(16'h0000), .rf_rb_data(16'h0000),
    .rf_we(wd_rf_we), .rf_waddr(wd_rf_waddr), .rf_wdata(wd_rf_wdata),
    .alu_a(wd_alu_a), .alu_b(wd_alu_b), .alu_op(wd_alu_op), .alu_out(16'h0000), .alu_flags(5'b00000),
    .pc(wd_pc), .ir_out(wd_ir), .psr(wd_psr), .fault(wd_fault), .state_out(wd_state)
`ifdef STEP_DEBUG_EN
    , .dbg_halt(1'b0), .dbg_step(1'b0), .halted(wd_halted)
`endif
  );

  logic [DW-1:0] mem [512];
  logic [DW-1:0] rf [16];
  logic          ld_we = 1'b0, tb_rf_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0, tb_rf_data = '0;
  logic [3:0]    tb_rf_addr = '0;
  int            wait_n = 0;
  int            req_cnt = 0;

  assign mem_rdata  = mem[mem_addr];
  assign mem_ready  = mem_req && (req_cnt >= wait_n);
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
    if (tb_rf_we) rf[tb_rf_addr] <= tb_rf_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    req_cnt <= (mem_req && !mem_ready) ? req_cnt + 1 : 0;
  end

  // ALU flags {C,L,F,Z,N}: C is carry (ADD) or borrow (SUB/CMP), L is unsigned a<b
  logic [16:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (alu_op[3:0])
      4'b0101:          alu_s = {1'b0, alu_a} + {1'b0, alu_b};
      4'b1001, 4'b1011: alu_s = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0001:          alu_s = {1'b0, alu_a & alu_b};
      4'b0010:          alu_s = {1'b0, alu_a | alu_b};
      4'b0011:          alu_s = {1'b0, alu_a ^ alu_b};
      4'b1101:          alu_s = {1'b0, alu_b};
      default:          alu_s = '0;
    endcase
    alu_out   = alu_s[15:0];
    alu_flags = {alu_s[16], alu_a < alu_b, 1'b0, alu_s[15:0] == 16'h0000, alu_s[15]};
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk); ld_we = 1'b1; ld_addr = AW'(a); ld_data = d;
    @(negedge clk); ld_we = 1'b0;
  endtask

  task automatic set_rf(input int r, input logic [15:0] d);
    @(negedge clk); tb_rf_we = 1'b1; tb_rf_addr = 4'(r); tb_rf_data = d;
    @(negedge clk); tb_rf_we = 1'b0;
  endtask

  task automatic hold_reset();
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    tick(2);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_psr", psr, 0);
    chk("rst_state", state_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_strobes", {mem_req, mem_we, rf_we}, 0);

    // ADDI R1,#5; ADD R2,R1; ADDI R1,#-1; LUI R7,#BE; ORI R7,#EF; MOVI R8,#80
    load(0, 16'h5105); load(1, 16'h0251); load(2, 16'h51FF);
    load(3, 16'hF7BE); load(4, 16'h27EF); load(5, 16'hD880);
    set_rf(1, 16'h0000); set_rf(2, 16'h0003); set_rf(8, 16'hFFFF);
    release_reset();
    tick(3);
    chk("a_pc1", pc, 1);
    chk("a_r1", rf[1], 16'h0005);
    chk("wd_pre_fault", {wd_fault, wd_mem_req}, 2'b01);
    tick(1);
    chk("wd_fault", wd_fault, 1);
    chk("wd_state", wd_state, 4);
    chk("wd_strobes", {wd_mem_req, wd_mem_we, wd_rf_we}, 0);
    tick(2);
    chk("a_r2", rf[2], 16'h0008);
    chk("a_psr", psr, 5'b01000);
    chk("a_pc2", pc, 2);
    chk("a_state", state_out, 0);
    tick(12);
    chk("a_addi_neg", rf[1], 16'h0004);
    chk("a_lui_ori", rf[7], 16'hBEEF);
    chk("a_movi_zext", rf[8], 16'h0080);
    chk("a_psr_kept", psr, 5'b11000);
    chk("a_pc6", pc, 6);

    // CMP R1,R1; BEQ -3 -> wraps below zero
    hold_reset();
    load(0, 16'h01B1); load(1, 16'hC0FD);
    release_reset();
    tick(3);
    chk("b_cmp_psr", psr, 5'b00010);
    chk("b_cmp_r1", rf[1], 16'h0004);
    tick(3);
    chk("b_beq_pc", pc, 9'h1FE);
    hold_reset();
    load(1, 16'hC1FD);
    release_reset();
    tick(6);
    chk("b_bne_pc", pc, 2);

    // STOR R3,[R4]; LOAD R5,[R4] with three wait states
    hold_reset();
    load(0, 16'h4344); load(1, 16'h4504);
    set_rf(3, 16'hBEEF); set_rf(4, 16'h0010); set_rf(5, 16'h0000);
    wait_n = 3;
    release_reset();
    tick(6);
    chk("c_st_state", state_out, 3);
    chk("c_st_strobes", {mem_req, mem_we}, 2'b11);
    chk("c_st_addr", mem_addr, 9'h010);
    chk("c_st_wdata", mem_wdata, 16'hBEEF);
    n = 0;
    while (state_out == 3'd3 && n < 20) begin n++; tick(1); end
    chk("c_st_req_cycles", n, 4);
    chk("c_st_mem", mem[16], 16'hBEEF);
    chk("c_st_pc", pc, 1);
    n = 0;
    while (state_out == 3'd0 && n < 20) begin n++; tick(1); end
    chk("c_fetch_cycles", n, 4);
    tick(2);
    chk("c_ld_we", {mem_req, mem_we}, 2'b10);
    n = 0;
    while (state_out == 3'd3 && n < 20) begin n++; tick(1); end
    chk("c_ld_req_cycles", n, 4);
    chk("c_ld_r5", rf[5], 16'hBEEF);
    chk("c_ld_pc", pc, 2);

    // asynchronous reset while a store is waiting
    hold_reset();
    release_reset();
    tick(7);
    chk("g_mid_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("g_rst_req", mem_req, 0);
    chk("g_rst_pc", pc, 0);
    chk("g_rst_state", state_out, 0);
    wait_n = 0;

    // BR UC +7; JAL R14,R6
    load(0, 16'hCE07); load(7, 16'h4E86);
    set_rf(6, 16'h0040); set_rf(14, 16'h0000);
    release_reset();
    tick(3);
    chk("d_br_pc", pc, 7);
    tick(3);
    chk("d_jal_link", rf[14], 16'h0008);
    chk("d_jal_pc", pc, 9'h040);

    // illegal encoding
    hold_reset();
    load(0, 16'h4F2F);
    release_reset();
    tick(2);
    chk("e_exec", {state_out, fault}, {3'd2, 1'b0});
    tick(1);
    chk("e_fault", {state_out, fault}, {3'd4, 1'b1});
    chk("e_strobes", {mem_req, mem_we, rf_we}, 0);
    tick(5);
    chk("e_sticky", fault, 1);
    chk("e_pc_frozen", pc, 0);
    chk("e_ir_frozen", ir_out, 16'h4F2F);

`ifdef STEP_DEBUG_EN
    hold_reset();
    load(0, 16'h5105); load(1, 16'h0251); load(2, 16'h51FF);
    dbg_halt = 1'b1;
    release_reset();
    tick(6);
    chk("s_halted", halted, 1);
    chk("s_pc0", pc, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); dbg_step = 1'b1;
      @(negedge clk); dbg_step = 1'b0;
      tick(6);
    end
    chk("s_halted_after", halted, 1);
    chk("s_pc2", pc, 3);
    dbg_halt = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
